mem_xbar_rr: RTL and testbench

Parametrised N-port request/response crossbar between the core-side memory ports (HTIF plus cores) and the single L2/memory port. It arbitrates requesters round-robin, registers the winning request in a one-entry output stage, and prefixes each tag with the source port index. It also routes registered responses back to the owning port by that index. It sits in the top level between the HTIF/core memory interfaces and the L2 controller, and scales to any core count.

---
 rtl/mem_xbar_rr_if.sv | 60 ++++++
 rtl/mem_xbar_rr.sv | 153 +++++++++++++++
 tb/tb_mem_xbar_rr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_xbar_rr_if.sv
// mem_xbar_rr_if: bundles the core-side request/response ports and the single
// downstream memory port of the mem_xbar_rr crossbar.
// slave  = crossbar view, master = environment (cores, HTIF, L2) view.
// The MEM_*_BITS defaults apply only when the including build leaves them undefined.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

interface mem_xbar_rr_if #(
    parameter int NPORTS    = 3,
    parameter int ADDR_BITS = `MEM_ADDR_BITS,
    parameter int DATA_BITS = `MEM_DATA_BITS,
    parameter int TAG_BITS  = `MEM_TAG_BITS
);
    localparam int ID_BITS = $clog2(NPORTS);

    // core side
    logic [NPORTS-1:0]           req_val;
    logic [NPORTS-1:0]           req_rdy;
    logic [NPORTS-1:0]           req_rw;
    logic [NPORTS*ADDR_BITS-1:0] req_addr;
    logic [NPORTS*DATA_BITS-1:0] req_data;
    logic [NPORTS*TAG_BITS-1:0]  req_tag;
    logic [NPORTS-1:0]           resp_val;
    logic [NPORTS-1:0]           resp_nack;
    logic [DATA_BITS-1:0]        resp_data;
    logic [TAG_BITS-1:0]         resp_tag;

    // memory side
    logic                        mem_req_val;
    logic                        mem_req_rdy;
    logic                        mem_req_rw;
    logic [ADDR_BITS-1:0]        mem_req_addr;
    logic [DATA_BITS-1:0]        mem_req_data;
    logic [ID_BITS+TAG_BITS-1:0] mem_req_tag;
    logic                        mem_resp_val;
    logic                        mem_resp_nack;
    logic [DATA_BITS-1:0]        mem_resp_data;
    logic [ID_BITS+TAG_BITS-1:0] mem_resp_tag;

    modport slave (
        input  req_val, req_rw, req_addr, req_data, req_tag,
        output req_rdy, resp_val, resp_nack, resp_data, resp_tag,
        output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_rdy, mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );

    modport master (
        output req_val, req_rw, req_addr, req_data, req_tag,
        input  req_rdy, resp_val, resp_nack, resp_data, resp_tag,
        input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_rdy, mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/mem_xbar_rr.sv
// mem_xbar_rr: N-port round-robin request crossbar onto one memory port with a
// one-entry registered output stage, plus 1-cycle registered response routing
// by the source index carried in the upper tag bits.
// Optional feature macro XBAR_HTIF_PRIO_EN: port 0 (HTIF) always wins when it
// requests and its grants leave the round-robin pointer untouched.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module mem_xbar_rr #(
    parameter int NPORTS    = 3,
    parameter int ADDR_BITS = `MEM_ADDR_BITS,
    parameter int DATA_BITS = `MEM_DATA_BITS,
    parameter int TAG_BITS  = `MEM_TAG_BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_xbar_rr_if.slave  bus
);
    localparam int ID_BITS = $clog2(NPORTS);
    localparam int OT_BITS = ID_BITS + TAG_BITS;

    // per-port views of the flattened request buses
    logic [ADDR_BITS-1:0] w_addr_arr [NPORTS];
    logic [DATA_BITS-1:0] w_data_arr [NPORTS];
    logic [TAG_BITS-1:0]  w_tag_arr  [NPORTS];

    logic [NPORTS-1:0]    w_gnt;
    logic [ID_BITS-1:0]   w_gnt_idx;
    logic                 w_any;
    logic                 w_open;
    logic                 w_fire;
    logic [ID_BITS-1:0]   w_ptr_next;
    logic [ID_BITS-1:0]   w_resp_id;
    logic [NPORTS-1:0]    w_resp_hit;

    logic                 r_out_val;
    logic                 r_out_rw;
    logic [ADDR_BITS-1:0] r_out_addr;
    logic [DATA_BITS-1:0] r_out_data;
    logic [OT_BITS-1:0]   r_out_tag;
    logic [ID_BITS-1:0]   r_ptr;

    logic [NPORTS-1:0]    r_resp_val;
    logic [NPORTS-1:0]    r_resp_nack;
    logic [DATA_BITS-1:0] r_resp_data;
    logic [TAG_BITS-1:0]  r_resp_tag;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_BITS +: ADDR_BITS];
            assign w_data_arr[gi] = bus.req_data[gi*DATA_BITS +: DATA_BITS];
            assign w_tag_arr[gi]  = bus.req_tag[gi*TAG_BITS +: TAG_BITS];
            assign w_resp_hit[gi] = (w_resp_id == ID_BITS'(gi));
        end
    endgenerate

    // Round-robin search starting at r_ptr; iterating from the farthest offset
    // down lets the closest requester overwrite earlier candidates.
    always_comb begin
        logic [ID_BITS:0] v_j;
        v_j       = '0;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            v_j = {1'b0, r_ptr} + (ID_BITS+1)'(k);
            if (v_j >= (ID_BITS+1)'(NPORTS))
                v_j = v_j - (ID_BITS+1)'(NPORTS);
            if (bus.req_val[v_j[ID_BITS-1:0]]) begin
                w_gnt_idx = v_j[ID_BITS-1:0];
                w_any     = 1'b1;
            end
        end
`ifdef XBAR_HTIF_PRIO_EN
        if (bus.req_val[0]) begin
            w_gnt_idx = '0;
            w_any     = 1'b1;
        end
`endif
        if (w_any)
            w_gnt[w_gnt_idx] = 1'b1;
    end

    // The stage accepts when empty or draining this cycle; no grants while in reset.
    assign w_open      = ~r_out_val | bus.mem_req_rdy;
    assign w_fire      = w_any & w_open;
    assign bus.req_rdy = w_gnt & {NPORTS{w_open & reset_n}};

    assign w_ptr_next = (w_gnt_idx == ID_BITS'(NPORTS - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Output stage: load the winner, drain when downstream takes it, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_val  <= 1'b0;
            r_out_rw   <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_ptr      <= '0;
        end else if (w_fire) begin
            r_out_val  <= 1'b1;
            r_out_rw   <= bus.req_rw[w_gnt_idx];
            r_out_addr <= w_addr_arr[w_gnt_idx];
            r_out_data <= w_data_arr[w_gnt_idx];
            r_out_tag  <= {w_gnt_idx, w_tag_arr[w_gnt_idx]};
`ifdef XBAR_HTIF_PRIO_EN
            if (w_gnt_idx != '0)
                r_ptr <= w_ptr_next;
`else
            r_ptr <= w_ptr_next;
`endif
        end else if (bus.mem_req_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign bus.mem_req_val  = r_out_val;
    assign bus.mem_req_rw   = r_out_rw;
    assign bus.mem_req_addr = r_out_addr;
    assign bus.mem_req_data = r_out_data;
    assign bus.mem_req_tag  = r_out_tag;

    assign w_resp_id = bus.mem_resp_tag[OT_BITS-1 -: ID_BITS];

    // Response routing: val and nack decoded independently; out-of-range ids hit no port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_val  <= '0;
            r_resp_nack <= '0;
            r_resp_data <= '0;
            r_resp_tag  <= '0;
        end else begin
            r_resp_val  <= {NPORTS{bus.mem_resp_val}}  & w_resp_hit;
            r_resp_nack <= {NPORTS{bus.mem_resp_nack}} & w_resp_hit;
            r_resp_data <= bus.mem_resp_data;
            r_resp_tag  <= bus.mem_resp_tag[TAG_BITS-1:0];
        end
    end

    assign bus.resp_val  = r_resp_val;
    assign bus.resp_nack = r_resp_nack;
    assign bus.resp_data = r_resp_data;
    assign bus.resp_tag  = r_resp_tag;

endmodule

// File: tb/tb_mem_xbar_rr.sv
// tb_mem_xbar_rr: directed scenarios plus randomized traffic for mem_xbar_rr,
// checked against a transaction-level model kept in the bench.
`include "rtl/mem_xbar_rr_if.sv"

module tb_mem_xbar_rr;
    localparam int N  = 3;
    localparam int AB = 16;
    localparam int DB = 16;
    localparam int TB = 4;
    localparam int IB = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_xbar_rr_if #(.NPORTS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB)) bus ();

    mem_xbar_rr #(.NPORTS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // model: the pending downstream request and the last routed response
    int            m_out_val;
    int            m_ptr;
    logic          m_rw;
    logic [AB-1:0] m_addr;
    logic [DB-1:0] m_data;
    logic [IB+TB-1:0] m_tag;
    logic [N-1:0]  m_resp_val;
    logic [N-1:0]  m_resp_nack;
    logic [DB-1:0] m_resp_data;
    logic [TB-1:0] m_resp_tag;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_out_val = 0; m_ptr = 0; m_rw = 1'b0; m_addr = '0; m_data = '0; m_tag = '0;
        m_resp_val = '0; m_resp_nack = '0; m_resp_data = '0; m_resp_tag = '0;
    endtask

    // Winning port under the arbitration rules, or -1 when nobody asks.
    function automatic int model_grant();
`ifdef XBAR_HTIF_PRIO_EN
        if (bus.req_val[0]) return 0;
`endif
        for (int k = 0; k < N; k++)
            if (bus.req_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // One clock: called just after a falling edge with inputs already driven.
    task automatic step(output int g);
        int            n_out_val, n_ptr, id;
        logic          n_rw, open;
        logic [AB-1:0] n_addr;
        logic [DB-1:0] n_data;
        logic [IB+TB-1:0] n_tag;
        logic [N-1:0]  n_rv, n_rn;
        #1;
        g = model_grant();
        open = (m_out_val == 0) || bus.mem_req_rdy;
        chk("req_rdy", 64'(bus.req_rdy), (g >= 0 && open && reset_n) ? (64'd1 << g) : 64'd0);
        n_out_val = m_out_val; n_ptr = m_ptr; n_rw = m_rw;
        n_addr = m_addr; n_data = m_data; n_tag = m_tag;
        if (g >= 0 && open) begin
            n_out_val = 1;
            n_rw   = bus.req_rw[g];
            n_addr = bus.req_addr[g*AB +: AB];
            n_data = bus.req_data[g*DB +: DB];
            n_tag  = {IB'(g), bus.req_tag[g*TB +: TB]};
`ifdef XBAR_HTIF_PRIO_EN
            if (g != 0) n_ptr = (g + 1) % N;
`else
            n_ptr = (g + 1) % N;
`endif
        end else if (bus.mem_req_rdy) begin
            n_out_val = 0;
        end
        id   = int'(bus.mem_resp_tag[IB+TB-1 -: IB]);
        n_rv = (bus.mem_resp_val  && id < N) ? N'(1 << id) : '0;
        n_rn = (bus.mem_resp_nack && id < N) ? N'(1 << id) : '0;
        if (!reset_n) begin
            @(posedge clk); #1;
            model_reset();
        end else begin
            m_resp_data = bus.mem_resp_data;
            m_resp_tag  = bus.mem_resp_tag[TB-1:0];
            @(posedge clk); #1;
            m_out_val = n_out_val; m_ptr = n_ptr; m_rw = n_rw;
            m_addr = n_addr; m_data = n_data; m_tag = n_tag;
            m_resp_val = n_rv; m_resp_nack = n_rn;
        end
        chk("mem_req_val",  64'(bus.mem_req_val),  64'(m_out_val != 0));
        chk("mem_req_rw",   64'(bus.mem_req_rw),   64'(m_rw));
        chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(m_addr));
        chk("mem_req_data", 64'(bus.mem_req_data), 64'(m_data));
        chk("mem_req_tag",  64'(bus.mem_req_tag),  64'(m_tag));
        chk("resp_val",     64'(bus.resp_val),     64'(m_resp_val));
        chk("resp_nack",    64'(bus.resp_nack),    64'(m_resp_nack));
        chk("resp_data",    64'(bus.resp_data),    64'(m_resp_data));
        chk("resp_tag",     64'(bus.resp_tag),     64'(m_resp_tag));
        @(negedge clk);
    endtask

    task automatic quiet_resp();
        bus.mem_resp_val = 1'b0; bus.mem_resp_nack = 1'b0;
        bus.mem_resp_data = '0;  bus.mem_resp_tag = '0;
    endtask

    int g;
    logic [AB-1:0] saved_addr;
    int exp_seq [4];

    initial begin
        model_reset();
        // reset held with every input active
        reset_n = 1'b0;
        bus.req_val = '1; bus.req_rw = 3'b101;
        bus.req_addr = 48'h3333_2222_1111; bus.req_data = 48'hCCCC_BBBB_AAAA;
        bus.req_tag = {4'h3, 4'h2, 4'hA};
        bus.mem_req_rdy = 1'b1; bus.mem_resp_val = 1'b1; bus.mem_resp_nack = 1'b1;
        bus.mem_resp_data = 16'hBEEF; bus.mem_resp_tag = 6'h11;
        @(negedge clk);
        repeat (2) step(g);
        chk("rst_mem_req_val", 64'(bus.mem_req_val), 64'd0);
        chk("rst_resp_val",    64'(bus.resp_val),    64'd0);
        chk("rst_req_rdy",     64'(bus.req_rdy),     64'd0);

        // first request after release, from port 0
        reset_n = 1'b1; bus.req_val = 3'b001; quiet_resp();
        step(g);
        chk("first_val", 64'(bus.mem_req_val), 64'd1);
        chk("first_tag", 64'(bus.mem_req_tag), 64'h0A);
        $display("txn first: tag=0x%0h addr=0x%0h", bus.mem_req_tag, bus.mem_req_addr);

        // fairness from a fresh pointer
        reset_n = 1'b0; step(g); reset_n = 1'b1;
        bus.req_val = '1;
        for (int i = 0; i < 6; i++) begin
            step(g);
            chk("fair_idx", 64'(bus.mem_req_tag[IB+TB-1 -: IB]), 64'(i % 3));
            $display("txn fair %0d: idx=%0d", i, bus.mem_req_tag[IB+TB-1 -: IB]);
        end

        // backpressure with port 1 pending
        bus.req_val = 3'b010; bus.req_addr[AB +: AB] = 16'h1234;
        step(g);
        saved_addr = bus.mem_req_addr;
        chk("bp_load_addr", 64'(saved_addr), 64'h1234);
        bus.mem_req_rdy = 1'b0; bus.req_addr[AB +: AB] = 16'h5678;
        for (int i = 0; i < 4; i++) begin
            step(g);
            chk("bp_addr_hold", 64'(bus.mem_req_addr), 64'(saved_addr));
            chk("bp_rdy_low",   64'(bus.req_rdy),      64'd0);
            $display("txn stall %0d: addr=0x%0h rdy=%b", i, bus.mem_req_addr, bus.req_rdy);
        end
        bus.mem_req_rdy = 1'b1;
        step(g);
        chk("bp_accept", 64'(bus.mem_req_addr), 64'h5678);
        bus.req_val = '0;

        // response routing
        bus.mem_resp_val = 1'b1; bus.mem_resp_tag = {2'd2, 4'h5}; bus.mem_resp_data = 16'hCAFE;
        step(g);
        chk("route_val", 64'(bus.resp_val), 64'b100);
        chk("route_tag", 64'(bus.resp_tag), 64'h5);
        bus.mem_resp_tag = {2'd3, 4'h7};
        step(g);
        chk("route_drop", 64'(bus.resp_val), 64'd0);
        bus.mem_resp_val = 1'b0; bus.mem_resp_nack = 1'b1; bus.mem_resp_tag = {2'd1, 4'h9};
        step(g);
        chk("route_nack", 64'(bus.resp_nack), 64'b010);
        chk("route_nval", 64'(bus.resp_val),  64'd0);
        $display("txn resp: val=%b nack=%b tag=0x%0h", bus.resp_val, bus.resp_nack, bus.resp_tag);
        quiet_resp();
        step(g);

        // ports 0 and 2 competing with the pointer at 2
`ifdef XBAR_HTIF_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{2, 0, 2, 0};
`endif
        bus.req_val = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step(g);
            chk("prio_idx", 64'(bus.mem_req_tag[IB+TB-1 -: IB]), 64'(exp_seq[i]));
            $display("txn prio %0d: idx=%0d", i, bus.mem_req_tag[IB+TB-1 -: IB]);
        end

        // asynchronous reset while the stage is stalled
        bus.req_val = 3'b001; bus.mem_req_rdy = 1'b0;
        step(g);
        chk("stall_val", 64'(bus.mem_req_val), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_val", 64'(bus.mem_req_val), 64'd0);
        chk("async_tag", 64'(bus.mem_req_tag), 64'd0);
        model_reset();
        @(negedge clk);
        step(g);
        reset_n = 1'b1; bus.mem_req_rdy = 1'b1;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.req_val       = N'($urandom_range(0, 7));
            bus.req_rw        = N'($urandom_range(0, 7));
            bus.req_addr      = {16'($urandom), 16'($urandom), 16'($urandom)};
            bus.req_data      = {16'($urandom), 16'($urandom), 16'($urandom)};
            bus.req_tag       = 12'($urandom);
            bus.mem_req_rdy   = ($urandom_range(0, 9) < 7);
            bus.mem_resp_val  = 1'($urandom);
            bus.mem_resp_nack = ($urandom_range(0, 3) == 0);
            bus.mem_resp_data = 16'($urandom);
            bus.mem_resp_tag  = 6'($urandom_range(0, 63));
            step(g);
            if (i % 100 == 0)
                $display("txn rand %0d: gnt=%0d mem_req_val=%b tag=0x%0h resp_val=%b",
                         i, g, bus.mem_req_val, bus.mem_req_tag, bus.resp_val);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
